// File: rtl/join_scheduler_pkg.sv
// join_sched_pkg: FSM states, default sizes and width helpers shared by join_scheduler, its interface, arbiter and bench
package join_sched_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, ARM, COLLECT, RESULT} state_t;
  function automatic int lane_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(int bw);
    return $clog2(bw) + 1;
  endfunction
  localparam int NUM_REQ_DEF = 4;
  localparam int BW_DEF = 128;
  localparam int WW_DEF = 8;
  localparam int ACC_DEF = 16;
  localparam int LANE_W = lane_w(NUM_REQ_DEF);
  localparam int CNT_W = cnt_w(BW_DEF);
endpackage

// File: rtl/join_scheduler_if.sv
// join_scheduler_if: request/join-unit/result bundle; slave = scheduler side, master = lanes + join unit + result sink
interface join_scheduler_if import join_sched_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int BITMASK_WIDTH = BW_DEF,
  parameter int WEIGHT_WIDTH = WW_DEF,
  parameter int ACC_WIDTH = ACC_DEF,
  localparam int LW = lane_w(NUM_REQ),
  localparam int CW = cnt_w(BITMASK_WIDTH)
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*BITMASK_WIDTH-1:0] req_bitmask_a;
  logic [NUM_REQ*BITMASK_WIDTH-1:0] req_bitmask_b;
  logic [LW-1:0] sel_lane;
  logic [BITMASK_WIDTH-1:0] join_and_result;
  logic [BITMASK_WIDTH-1:0] join_bitmask_b;
  logic join_valid_match;
  logic join_fast_valid;
  logic [WEIGHT_WIDTH-1:0] join_matched_weight;
  logic join_processing_done;
  logic res_valid;
  logic res_ready;
  logic [LW-1:0] res_lane;
  logic [ACC_WIDTH-1:0] res_sum;
  logic [CW-1:0] res_count;
  logic res_timeout;
  modport slave (
    input req_valid, req_bitmask_a, req_bitmask_b, join_fast_valid, join_matched_weight,
          join_processing_done, res_ready,
    output req_ready, sel_lane, join_and_result, join_bitmask_b, join_valid_match,
           res_valid, res_lane, res_sum, res_count, res_timeout
  );
  modport master (
    output req_valid, req_bitmask_a, req_bitmask_b, join_fast_valid, join_matched_weight,
           join_processing_done, res_ready,
    input req_ready, sel_lane, join_and_result, join_bitmask_b, join_valid_match,
          res_valid, res_lane, res_sum, res_count, res_timeout
  );
endinterface

// File: rtl/join_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr (wrapping); ports req, ptr, grant (one-hot), grant_idx
module rr_arbiter import join_sched_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  localparam int LW = lane_w(NUM_REQ)
)(
  input  logic [NUM_REQ-1:0] req,
  input  logic [LW-1:0] ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [LW-1:0] grant_idx
);
  logic found;
  int idx;
  always_comb begin
    grant = '0;
    grant_idx = '0;
    found = 1'b0;
    idx = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        grant[idx] = 1'b1;
        grant_idx = LW'(idx);
      end
    end
  end
endmodule

// File: rtl/join_scheduler.sv
// join_scheduler: round-robin share of one inner-join unit across NUM_REQ lanes, accumulating matched weights per job; ports clk, rst, bus (join_scheduler_if.slave); JOIN_ZERO_SKIP_EN sends empty jobs straight to RESULT
module join_scheduler import join_sched_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int BITMASK_WIDTH = BW_DEF,
  parameter int WEIGHT_WIDTH = WW_DEF,
  parameter int ACC_WIDTH = ACC_DEF,
  parameter int TIMEOUT = BITMASK_WIDTH + 8
)(
  input logic clk,
  input logic rst,
  join_scheduler_if.slave bus
);
  localparam int LW = lane_w(NUM_REQ);
  localparam int CW = cnt_w(BITMASK_WIDTH);
  localparam int WDW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [LW-1:0] rr_ptr, g_idx, sel;
  logic [NUM_REQ-1:0] g_hot;
  logic [BITMASK_WIDTH-1:0] a_g, b_g, and_r, b_r;
  logic [ACC_WIDTH-1:0] acc;
  logic [CW-1:0] cnt;
  logic [WDW-1:0] wd;
  logic tmo, any_req, wd_exp, grant_now;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (.req(bus.req_valid), .ptr(rr_ptr), .grant(g_hot), .grant_idx(g_idx));
  assign any_req = |bus.req_valid;
  assign grant_now = state == IDLE && any_req;
  assign a_g = bus.req_bitmask_a[g_idx*BITMASK_WIDTH +: BITMASK_WIDTH];
  assign b_g = bus.req_bitmask_b[g_idx*BITMASK_WIDTH +: BITMASK_WIDTH];
  assign wd_exp = int'(wd) + 1 >= TIMEOUT;
  assign bus.req_ready = (state == IDLE && !rst) ? g_hot : '0;
  assign bus.join_valid_match = state == ISSUE && bus.join_processing_done;
  assign bus.res_valid = state == RESULT;
  assign bus.sel_lane = sel;
  assign bus.res_lane = sel;
  assign bus.join_and_result = and_r;
  assign bus.join_bitmask_b = b_r;
  assign bus.res_sum = acc;
  assign bus.res_count = cnt;
  assign bus.res_timeout = tmo;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:
        if (any_req) begin
`ifdef JOIN_ZERO_SKIP_EN
          state_n = ((a_g & b_g) == '0) ? RESULT : ISSUE;
`else
          state_n = ISSUE;
`endif
        end
      ISSUE: state_n = bus.join_processing_done ? ARM : ISSUE;
      ARM: state_n = COLLECT;
      COLLECT: state_n = (bus.join_processing_done || wd_exp) ? RESULT : COLLECT;
      RESULT: state_n = bus.res_ready ? IDLE : RESULT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      sel <= '0;
      and_r <= '0;
      b_r <= '0;
      acc <= '0;
      cnt <= '0;
      wd <= '0;
      tmo <= 1'b0;
    end else begin
      state <= state_n;
      if (grant_now) begin
        sel <= g_idx;
        and_r <= a_g & b_g;
        b_r <= b_g;
        acc <= '0;
        cnt <= '0;
        wd <= '0;
        tmo <= 1'b0;
      end
      if (state == COLLECT) begin
        if (bus.join_fast_valid) begin
          acc <= acc + {{(ACC_WIDTH-WEIGHT_WIDTH){bus.join_matched_weight[WEIGHT_WIDTH-1]}}, bus.join_matched_weight};
          cnt <= cnt + CW'(1);
        end
        wd <= wd + WDW'(1);
        tmo <= !bus.join_processing_done && wd_exp;
      end
      if (state == RESULT && bus.res_ready)
        rr_ptr <= (sel == LW'(NUM_REQ - 1)) ? '0 : sel + LW'(1);
    end
  end
endmodule

// File: tb/tb_join_scheduler.sv
// tb_join_scheduler: directed scoreboard bench for join_scheduler with a behavioural join-unit model
module tb_join_scheduler;
  import join_sched_pkg::*;
  localparam int NR = 4, BW = 128, WW = 8, AW = 16, TO = BW + 8;
  typedef struct {int lane; int sum; int cnt; int tmo; int lat;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  join_scheduler_if #(.NUM_REQ(NR), .BITMASK_WIDTH(BW), .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW)) bus ();
  join_scheduler #(.NUM_REQ(NR), .BITMASK_WIDTH(BW), .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  logic m_done, m_fv, m_busy, m_hang;
  logic [WW-1:0] m_w;
  logic signed [WW-1:0] mw [8];
  int m_k, m_n;
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b1;
      m_fv <= 1'b0;
      m_w <= '0;
      m_k <= 0;
    end else if (bus.join_valid_match) begin
      m_busy <= 1'b1;
      m_done <= 1'b0;
      m_fv <= 1'b0;
      m_k <= 0;
    end else if (m_busy) begin
      if (m_k < m_n) begin
        m_fv <= 1'b1;
        m_w <= mw[m_k];
        m_k <= m_k + 1;
      end else begin
        m_fv <= 1'b0;
        m_done <= !m_hang;
        m_busy <= m_hang;
      end
    end
  end
  assign bus.join_processing_done = m_done;
  assign bus.join_fast_valid = m_fv;
  assign bus.join_matched_weight = m_w;
  int n_chk = 0, n_pass = 0, n_vm = 0, cyc = 0, g_cyc = 0, vm0 = 0;
  exp_t sb[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.join_valid_match === 1'b1) n_vm <= n_vm + 1;
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask
  task automatic set_lane(int l, logic [BW-1:0] a, logic [BW-1:0] b);
    bus.req_bitmask_a[l*BW +: BW] = a;
    bus.req_bitmask_b[l*BW +: BW] = b;
  endtask
  task automatic wait_grant(int lane, string tag);
    int t = 0;
    #1;
    while (bus.req_ready === '0 && t < 50) begin tick(); t++; end
    chk(tag, bus.req_ready, 128'(1) << lane);
    g_cyc = cyc;
  endtask
  task automatic check_res(string tag);
    exp_t e;
    logic [AW-1:0] es;
    logic [LANE_W-1:0] el;
    logic [CNT_W-1:0] ec;
    int t = 0;
    while (bus.res_valid !== 1'b1 && t < 400) begin tick(); t++; end
    chk({tag, "_valid"}, bus.res_valid, 1);
    chk({tag, "_sb"}, sb.size(), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    es = AW'(e.sum);
    el = LANE_W'(e.lane);
    ec = CNT_W'(e.cnt);
    chk({tag, "_lane"}, bus.res_lane, el);
    chk({tag, "_sum"}, bus.res_sum, es);
    chk({tag, "_count"}, bus.res_count, ec);
    chk({tag, "_timeout"}, bus.res_timeout, e.tmo);
    chk({tag, "_latency"}, cyc - g_cyc, e.lat);
  endtask
  task automatic ack(string tag);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk({tag, "_ack"}, bus.res_valid, 0);
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_bitmask_a = '0;
    bus.req_bitmask_b = '0;
    bus.res_ready = 1'b0;
    m_n = 0;
    m_hang = 1'b0;
    for (int i = 0; i < 8; i++) mw[i] = '0;
    repeat (3) tick();
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_sel_lane", bus.sel_lane, 0);
    chk("rst_and", bus.join_and_result, 0);
    chk("rst_b", bus.join_bitmask_b, 0);
    chk("rst_vm", bus.join_valid_match, 0);
    chk("rst_sum", bus.res_sum, 0);
    chk("rst_count", bus.res_count, 0);
    chk("rst_timeout", bus.res_timeout, 0);
    chk("rst_ready", bus.req_ready, 0);
    rst = 1'b0;
    tick();
    m_n = 4;
    mw[0] = 3; mw[1] = -1; mw[2] = 5; mw[3] = 2;
    set_lane(2, 'hF, 'hF);
    bus.req_valid = 4'b0100;
    wait_grant(2, "a_grant");
    sb.push_back('{lane: 2, sum: 9, cnt: 4, tmo: 0, lat: 8});
    tick();
    bus.req_valid = '0;
    chk("a_pulse", bus.req_ready, 0);
    chk("a_sel", bus.sel_lane, 2);
    chk("a_and", bus.join_and_result, 'hF);
    chk("a_b", bus.join_bitmask_b, 'hF);
    check_res("a");
    set_lane(0, 'hFF, 'hF0);
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", bus.res_valid, 1);
      chk("hold_sum", bus.res_sum, 9);
      chk("hold_lane", bus.res_lane, 2);
      chk("hold_ready", bus.req_ready, 0);
    end
    m_n = 4;
    mw[0] = -128; mw[1] = -128; mw[2] = 127; mw[3] = 1;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("next_grant", bus.req_ready, 4'b0001);
    chk("next_valid", bus.res_valid, 0);
    g_cyc = cyc;
    sb.push_back('{lane: 0, sum: -128, cnt: 4, tmo: 0, lat: 8});
    tick();
    bus.req_valid = '0;
    chk("b_and", bus.join_and_result, 'hF0);
    check_res("b");
    ack("b");
    m_n = 0;
    set_lane(1, 'h5, 'hA);
    vm0 = n_vm;
    bus.req_valid = 4'b0010;
    wait_grant(1, "e_grant");
`ifdef JOIN_ZERO_SKIP_EN
    sb.push_back('{lane: 1, sum: 0, cnt: 0, tmo: 0, lat: 1});
`else
    sb.push_back('{lane: 1, sum: 0, cnt: 0, tmo: 0, lat: 4});
`endif
    tick();
    bus.req_valid = '0;
    check_res("empty");
`ifdef JOIN_ZERO_SKIP_EN
    chk("empty_vm", n_vm - vm0, 0);
`else
    chk("empty_vm", n_vm - vm0, 1);
`endif
    ack("empty");
    m_n = 2;
    mw[0] = 7; mw[1] = 8;
    m_hang = 1'b1;
    set_lane(3, 'h3, 'h3);
    bus.req_valid = 4'b1000;
    wait_grant(3, "t_grant");
    sb.push_back('{lane: 3, sum: 15, cnt: 2, tmo: 1, lat: 3 + TO});
    tick();
    bus.req_valid = '0;
    check_res("tmo");
    m_hang = 1'b0;
    ack("tmo");
    tick();
    m_n = 5;
    for (int i = 0; i < 5; i++) mw[i] = WW'(i + 1);
    set_lane(1, 'h1F, 'h1F);
    bus.req_valid = 4'b0010;
    wait_grant(1, "r_grant");
    tick();
    bus.req_valid = '0;
    repeat (5) tick();
    chk("r_pre_count", bus.res_count, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_valid", bus.res_valid, 0);
    chk("r_count", bus.res_count, 0);
    chk("r_sum", bus.res_sum, 0);
    chk("r_sel", bus.sel_lane, 0);
    chk("r_and", bus.join_and_result, 0);
    chk("r_vm", bus.join_valid_match, 0);
    chk("r_ready", bus.req_ready, 0);
    repeat (10) tick();
    chk("r_no_result", bus.res_valid, 0);
    for (int l = 0; l < NR; l++) set_lane(l, 'h3, 'h3);
    m_n = 2;
    bus.req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      int l;
      l = j % NR;
      wait_grant(l, "rr_grant");
      mw[0] = WW'(l + 1);
      mw[1] = WW'(2 * l);
      sb.push_back('{lane: l, sum: 3 * l + 1, cnt: 2, tmo: 0, lat: 6});
      tick();
      chk("rr_pulse", bus.req_ready, 0);
      check_res("rr");
      ack("rr");
    end
    bus.req_valid = '0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
